serial_paralelo_rx: RTL



---
 rtl/sprx_pkg.sv | 15 +
 rtl/serial_paralelo_rx_if.sv | 20 ++
 rtl/sprx_shift8.sv | 19 +
 rtl/serial_paralelo_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sprx_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package sprx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sprx_state_e;

  localparam logic [7:0]  SPRX_COM_BYTE  = 8'hBC;
  localparam logic [7:0]  SPRX_IDLE_BYTE = 8'h7C;
  localparam int unsigned SPRX_CNT_W     = 4;
  localparam int unsigned SPRX_BIT_W     = 3;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial lane in, parallel byte and link status out.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic       com_out;

  modport master (
    input  data_in,
    output data_out, valid_out, active_out, com_out
  );

  modport slave (
    output data_in,
    input  data_out, valid_out, active_out, com_out
  );

endinterface

// File: rtl/sprx_shift8.sv
// 8-bit MSB-first shift register; nxt_c is the window including the current bit.
module sprx_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] nxt_c
);

  logic [7:0] shift_reg;

  assign nxt_c = {shift_reg[6:0], data_in};

  // Shift one serial bit in per clock.
  always_ff @(posedge clk_32f) begin
    if (reset) shift_reg <= '0;
    else       shift_reg <= nxt_c;
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: comma hunt, byte alignment, lock and byte delivery.
// Optional loss-of-signal on consecutive idle bytes: define SPRX_LOS_EN.
module serial_paralelo_rx
  import sprx_pkg::*;
#(
  parameter logic [7:0]  COM_BYTE   = SPRX_COM_BYTE,
  parameter logic [7:0]  IDLE_BYTE  = SPRX_IDLE_BYTE,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOS_LIMIT  = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.master bus
);

  localparam logic [SPRX_CNT_W-1:0] LOCK_CNT_C = SPRX_CNT_W'(LOCK_COUNT);

  logic [7:0]            nxt_c;
  sprx_state_e           state_q, state_d;
  logic [SPRX_BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPRX_CNT_W-1:0] com_cnt_q, com_cnt_d;
  logic [SPRX_CNT_W-1:0] com_inc_c;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  active_q, active_d;
  logic                  com_q, com_d;
  logic                  boundary_c;
  logic                  is_com_c;

`ifdef SPRX_LOS_EN
  localparam logic [SPRX_CNT_W-1:0] LOS_CNT_C = SPRX_CNT_W'(LOS_LIMIT);
  logic [SPRX_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [SPRX_CNT_W-1:0] idle_inc_c;
`else
  logic unused_cfg_c;
  assign unused_cfg_c = ^{IDLE_BYTE, SPRX_CNT_W'(LOS_LIMIT)};
`endif

  sprx_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (bus.data_in),
    .nxt_c   (nxt_c)
  );

  assign boundary_c = (bit_cnt_q == SPRX_BIT_W'(7));
  assign is_com_c   = (nxt_c == COM_BYTE);
  assign com_inc_c  = SPRX_CNT_W'(com_cnt_q + SPRX_CNT_W'(1));

  // State and registered outputs.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SEARCH;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      com_q      <= 1'b0;
`ifdef SPRX_LOS_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      com_q      <= com_d;
`ifdef SPRX_LOS_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  // Next-state: hunt, align, lock and byte delivery.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = SPRX_BIT_W'(bit_cnt_q + SPRX_BIT_W'(1));
    com_cnt_d  = com_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    active_d   = active_q;
    com_d      = 1'b0;
`ifdef SPRX_LOS_EN
    idle_cnt_d = idle_cnt_q;
    idle_inc_c = SPRX_CNT_W'(idle_cnt_q + SPRX_CNT_W'(1));
`endif
    case (state_q)
      SEARCH: begin
        if (is_com_c) begin
          bit_cnt_d = '0;
          com_cnt_d = SPRX_CNT_W'(1);
          com_d     = 1'b1;
          if (LOCK_COUNT == 1) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d  = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (boundary_c) begin
          if (is_com_c) begin
            com_d = 1'b1;
            if (com_inc_c >= LOCK_CNT_C) begin
              com_cnt_d = LOCK_CNT_C;
              state_d   = LOCKED;
              active_d  = 1'b1;
            end else begin
              com_cnt_d = com_inc_c;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (boundary_c) begin
          if (is_com_c) begin
            com_d = 1'b1;
          end else begin
            data_d  = nxt_c;
            valid_d = 1'b1;
          end
`ifdef SPRX_LOS_EN
          if (nxt_c == IDLE_BYTE) begin
            if (idle_inc_c == LOS_CNT_C) begin
              state_d    = SEARCH;
              active_d   = 1'b0;
              com_cnt_d  = '0;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_inc_c;
            end
          end else begin
            idle_cnt_d = '0;
          end
`endif
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.active_out = active_q;
  assign bus.com_out    = com_q;

endmodule
